// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_BYTES = 512;
  localparam int unsigned IMEM_AW    = 9;
  localparam int unsigned IMEM_WAW   = IMEM_AW - 2;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_NPC = 32'h0000_0004;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/if_fetch_unit_imem.sv
// 512-byte instruction memory: one byte write port, one big-endian 32-bit
// combinational word read port.
module imem_512x8
  import if_fetch_unit_pkg::*;
(
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [IMEM_AW-1:0]  waddr_i,
  input  logic [BYTE_W-1:0]   wdata_i,
  input  logic [IMEM_WAW-1:0] rword_i,
  output logic [XLEN-1:0]     rdata_o
);

  logic [BYTE_W-1:0] mem_q [IMEM_BYTES];

  // Contents survive reset; only preload writes change them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = {mem_q[{rword_i, 2'b00}],
               mem_q[{rword_i, 2'b01}],
               mem_q[{rword_i, 2'b10}],
               mem_q[{rword_i, 2'b11}]};
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC/nPC pair with one delay slot, fetch-valid
// flag and the preloadable instruction memory.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                LE,
  input  logic                BRANCH_TAKEN,
  input  logic [XLEN-1:0]     TARGET_ADDR,
  input  logic                PRELOAD_EN,
  input  logic [IMEM_AW-1:0]  PRELOAD_ADDR,
  input  logic [BYTE_W-1:0]   PRELOAD_DATA,
  output logic [XLEN-1:0]     INSTR,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     NPC,
  output logic                FETCH_VALID
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            valid_q;

  // A stall holds both registers and drops any branch presented meanwhile.
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (LE) begin
      pc_d  = npc_q;
      npc_d = BRANCH_TAKEN ? TARGET_ADDR : npc_q + PC_INCR;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_NPC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      valid_q <= 1'b1;
    end
  end

  imem_512x8 u_imem (
    .clk_i   (Clk),
    .we_i    (PRELOAD_EN),
    .waddr_i (PRELOAD_ADDR),
    .wdata_i (PRELOAD_DATA),
    .rword_i (pc_q[IMEM_AW-1:2]),
    .rdata_o (INSTR)
  );

  assign PC          = pc_q;
  assign NPC         = npc_q;
  assign FETCH_VALID = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: reference model of the fetch rules
// compared every cycle, plus hand-computed directed expectations.
module tb_if_fetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic        LE;
  logic        BRANCH_TAKEN;
  logic [31:0] TARGET_ADDR;
  logic        PRELOAD_EN;
  logic [8:0]  PRELOAD_ADDR;
  logic [7:0]  PRELOAD_DATA;
  logic [31:0] INSTR;
  logic [31:0] PC;
  logic [31:0] NPC;
  logic        FETCH_VALID;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .LE           (LE),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .TARGET_ADDR  (TARGET_ADDR),
    .PRELOAD_EN   (PRELOAD_EN),
    .PRELOAD_ADDR (PRELOAD_ADDR),
    .PRELOAD_DATA (PRELOAD_DATA),
    .INSTR        (INSTR),
    .PC           (PC),
    .NPC          (NPC),
    .FETCH_VALID  (FETCH_VALID)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: byte array plus the architectural fetch pair.
  logic [7:0]  m_mem [512];
  logic [31:0] m_pc, m_npc;
  logic        m_valid;
  bit          m_live   = 1'b0;
  bit          m_loaded = 1'b0;

  function automatic logic [31:0] m_word(input logic [31:0] addr);
    int base;
    base = int'(addr % 32'd512) & ~3;
    return {m_mem[base], m_mem[base+1], m_mem[base+2], m_mem[base+3]};
  endfunction

  always @(posedge Clk) begin
    logic [31:0] succ;
    if (PRELOAD_EN) m_mem[PRELOAD_ADDR] = PRELOAD_DATA;
    if (!Reset_n) begin
      m_pc    = 32'h0;
      m_npc   = 32'h4;
      m_valid = 1'b0;
      m_live  = 1'b1;
    end else begin
      m_valid = 1'b1;
      if (LE) begin
        succ  = BRANCH_TAKEN ? TARGET_ADDR : m_npc + 32'd4;
        m_pc  = m_npc;
        m_npc = succ;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (m_live) begin
      chk("model PC", PC, m_pc);
      chk("model NPC", NPC, m_npc);
      chk("model FETCH_VALID", 32'(FETCH_VALID), 32'(m_valid));
      if (m_loaded) chk("model INSTR", INSTR, m_word(m_pc));
    end
  end

  task automatic drive(input logic rst_n, input logic le, input logic br,
                       input logic [31:0] tgt, input logic pen,
                       input logic [8:0] paddr, input logic [7:0] pdata);
    Reset_n      = rst_n;
    LE           = le;
    BRANCH_TAKEN = br;
    TARGET_ADDR  = tgt;
    PRELOAD_EN   = pen;
    PRELOAD_ADDR = paddr;
    PRELOAD_DATA = pdata;
    @(posedge Clk);
    #1;
  endtask

  task automatic preload_word(input logic [8:0] addr, input logic [31:0] w);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = w[31-8*k -: 8];
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, addr + 9'(k), b);
    end
  endtask

  initial begin
    Reset_n = 1'b0; LE = 1'b1; BRANCH_TAKEN = 1'b0; TARGET_ADDR = 32'h0;
    PRELOAD_EN = 1'b0; PRELOAD_ADDR = 9'h0; PRELOAD_DATA = 8'h0;

    // Fill memory with byte(i) = i[7:0] ^ 0xA5 while in reset.
    for (int i = 0; i < 512; i++)
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 9'(i), 8'(i) ^ 8'hA5);
    preload_word(9'h000, 32'h1111_1111);
    preload_word(9'h004, 32'h2222_2222);
    preload_word(9'h008, 32'h3333_3333);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    m_loaded = 1'b1;

    chk("reset PC", PC, 32'h0);
    chk("reset NPC", NPC, 32'h4);
    chk("reset FETCH_VALID", 32'(FETCH_VALID), 32'h0);
    chk("reset INSTR", INSTR, 32'h1111_1111);

    // Sequential fetch after release.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    chk("seq PC1", PC, 32'h4);
    chk("seq INSTR1", INSTR, 32'h2222_2222);
    chk("seq FETCH_VALID", 32'(FETCH_VALID), 32'h1);

    // Delay slot: branch at PC=4/NPC=8.
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 9'h0, 8'h0);
    chk("slot PC", PC, 32'h8);
    chk("slot NPC", NPC, 32'h40);
    chk("seq INSTR2", INSTR, 32'h3333_3333);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    chk("target PC", PC, 32'h40);
    chk("target NPC", NPC, 32'h44);

    // Reset in the same cycle as a taken branch.
    drive(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 9'h0, 8'h0);
    chk("rstbr PC", PC, 32'h0);
    chk("rstbr NPC", NPC, 32'h4);
    chk("rstbr FETCH_VALID", 32'(FETCH_VALID), 32'h0);
    chk("rstbr INSTR", INSTR, 32'h1111_1111);

    // Reach PC=8, then stall three cycles with a branch presented.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 9'h0, 8'h0);
      chk("stall PC", PC, 32'h8);
      chk("stall NPC", NPC, 32'hC);
      chk("stall INSTR", INSTR, 32'h3333_3333);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    chk("unstall PC", PC, 32'hC);
    chk("unstall NPC", NPC, 32'h10);

    // Same-word preload at PC=0x10.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    chk("pre-write INSTR", INSTR, 32'hB5B4_B7B6);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 9'h011, 8'hAB);
    chk("post-write INSTR", INSTR, 32'hB5AB_B7B6);

    // Wrap through 0xFFFFFFFC.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 9'h0, 8'h0);
    chk("wrap NPC1", NPC, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    chk("wrap PC", PC, 32'hFFFF_FFFC);
    chk("wrap NPC2", NPC, 32'h0);
    chk("wrap INSTR", INSTR, 32'h5958_5B5A);
    drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 9'h0, 8'h0);
    chk("wrap PC0", PC, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 9'h0, 8'h0);
    chk("alias PC", PC, 32'h200);
    chk("alias INSTR", INSTR, 32'h1111_1111);

    // Mixed tail checked by the model alone.
    for (int r = 0; r < 60; r++)
      drive(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 2) == 0),
            9'($urandom), 8'($urandom));

    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Clocking SHALL be a single clock, Clk; Reset_n SHALL be a synchronous, active-low reset sampled on the rising edge of Clk.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset_n  input  1  synchronous active-low reset.
REQ-004 LE  input  1  load enable; 1 = advance PC/nPC, 0 = stall (hold); shared with the IF/ID register LE.
REQ-005 BRANCH_TAKEN  input  1  branch/jump resolved taken this cycle.
REQ-006 TARGET_ADDR  input  32  branch/jump target address.
REQ-007 PRELOAD_EN  input  1  byte write strobe into instruction memory.
REQ-008 PRELOAD_ADDR  input  9  byte address of the preload write.
REQ-009 PRELOAD_DATA  input  8  byte to write.
REQ-010 INSTR  output  32  instruction at PC; feeds the IF/ID instruction input.
REQ-011 PC  output  32  current PC; feeds the IF/ID PC input.
REQ-012 NPC  output  32  next PC (delay-slot successor).
REQ-013 FETCH_VALID  output  1  0 while in reset and for the first cycle after reset release; 1 afterwards.

Function
REQ-014 The PC and nPC registers SHALL update only on a rising edge of Clk with Reset_n=1 and LE=1.
REQ-015 On an update edge, the block SHALL load PC with NPC, and NPC with TARGET_ADDR if BRANCH_TAKEN=1, else with NPC+4. This gives one architectural delay slot.
REQ-016 When LE=0, PC, NPC and INSTR SHALL hold, and BRANCH_TAKEN SHALL be ignored; upstream re-presents the branch when LE returns to 1.
REQ-017 NPC+4 SHALL be computed modulo 2^32; at 0xFFFFFFFC it SHALL wrap to 0x00000000 with no flag.
REQ-018 Instruction memory SHALL hold 512 bytes in big-endian order.
REQ-019 INSTR SHALL be combinational from PC: {mem[a], mem[a+1], mem[a+2], mem[a+3]} with a = {PC[8:2], 2'b00}. PC[31:9] and PC[1:0] SHALL be ignored, so addresses wrap modulo 512 and misaligned PCs read the enclosing word.
REQ-020 A preload write SHALL take effect at the rising edge where PRELOAD_EN=1, regardless of Reset_n and LE. INSTR SHALL reflect the new byte from that edge onward.
REQ-021 When a preload and a fetch address the same word in the same cycle, INSTR SHALL show the old data before the edge and the new data after it.
REQ-022 FETCH_VALID SHALL be a registered flag: cleared by reset, and set at the first rising edge with Reset_n=1. It SHALL be independent of LE.

Reset
REQ-023 When Reset_n=0 at a rising edge, PC SHALL become 0x00000000, NPC 0x00000004 and FETCH_VALID 0. This takes priority over LE and BRANCH_TAKEN.
REQ-024 Reset SHALL NOT clear instruction memory contents.
REQ-025 Reset asserted mid-operation, including in the cycle where BRANCH_TAKEN=1, SHALL discard the pending branch; fetch restarts at 0x00000000.
REQ-026 INSTR after reset SHALL equal the memory word at address 0.

Structure
REQ-027 A shared pipeline package SHALL hold the constants RESET_PC (0x00000000), RESET_NPC (0x00000004), PC_INCR (4) and IMEM_BYTES (512).
REQ-028 The instruction memory SHALL be a sub-module, imem_512x8, with one byte write port and one 32-bit big-endian combinational read port.
REQ-029 The PC/nPC logic and the FETCH_VALID flag SHALL live in if_fetch_unit.

Verification
REQ-030 Sequential fetch: preload words 0x11111111, 0x22222222, 0x33333333 at byte addresses 0, 4 and 8; release reset with LE=1 → over successive cycles PC=0,4,8 and INSTR=0x11111111, 0x22222222, 0x33333333; FETCH_VALID rises one edge after release.
REQ-031 Delay slot: BRANCH_TAKEN=1 with TARGET_ADDR=0x40 while PC=0x4 and NPC=0x8 → next PC=0x8 and NPC=0x40; the edge after that gives PC=0x40 and NPC=0x44.
REQ-032 Stall: hold LE=0 for 3 cycles at PC=0x8 while pulsing BRANCH_TAKEN=1 with TARGET_ADDR=0x80 → PC, NPC and INSTR stay unchanged; after LE=1, PC=0xC.
REQ-033 Wrap: force TARGET_ADDR=0xFFFFFFFC via a branch → NPC sequence 0xFFFFFFFC then 0x00000000; INSTR at PC=0x200 equals the word at 0x000.
REQ-034 Reset mid-branch: assert Reset_n=0 in the same cycle as BRANCH_TAKEN=1 → PC=0, NPC=4, FETCH_VALID=0; preloaded memory is intact.
REQ-035 Same-word preload: while PC=0x10, write byte 0xAB to address 0x11 → INSTR[23:16] changes to 0xAB after the edge; the other bytes are unchanged.
